mext_exec: RTL

- Execute-stage sequencer for RV64 M-extension ops.
- Accepts one op at a time from issue over a valid/ready handshake and drives the Mul multiplier unit (1-cycle registered latency), consuming its result.
- Runs an internal iterative radix-2 divider for DIV/DIVU/REM/REMU, including the word variants.
- Presents a single held result to writeback over a valid/ready handshake.

---
 rtl/mext_exec_pkg.sv | 32 +++
 rtl/mext_exec_div_iter.sv | 64 ++++++
 rtl/mext_exec.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mext_exec_pkg.sv
// Shared types for the M-extension execute stage and its multiplier interface.
package mul;
  typedef enum logic [1:0] {
    MOP_MUL,
    MOP_MULH,
    MOP_MULHSU,
    MOP_MULHU
  } op_t;
endpackage

package mext_exec_pkg;
  localparam int unsigned XLEN = 64;

  typedef enum logic [2:0] {
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } op_t;

  function automatic logic is_div(op_t op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic mul::op_t to_mul_op(op_t op);
    mul::op_t m;
    case (op)
      MULH:    m = mul::MOP_MULH;
      MULHSU:  m = mul::MOP_MULHSU;
      MULHU:   m = mul::MOP_MULHU;
      default: m = mul::MOP_MUL;
    endcase
    return m;
  endfunction
endpackage

// File: rtl/mext_exec_div_iter.sv
// Iterative unsigned restoring divider, one quotient bit per cycle,
// 32 iterations for word operands and XLEN iterations otherwise.
module mext_exec_div_iter
  import mext_exec_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            clear_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);
  localparam int unsigned CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  quo_q, rem_q, dvs_q, diff;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, word_q, ge;
  logic [XLEN:0]    partial;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    partial = {rem_q, quo_q[XLEN-1]};
    ge      = partial >= {1'b0, dvs_q};
    diff    = partial[XLEN-1:0] - dvs_q;
  end

  assign done_o      = busy_q && (cnt_q == (word_q ? CNT_W'(XLEN/2-1) : CNT_W'(XLEN-1)));
  assign busy_o      = busy_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  // Load operands on start, then shift one dividend bit in per cycle.
  // Word dividends are pre-shifted to the top so the same shift path serves both widths.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      word_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (clear_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      word_q <= word_i;
      dvs_q  <= divisor_i;
      rem_q  <= '0;
      quo_q  <= word_i ? {dividend_i[XLEN/2-1:0], {(XLEN/2){1'b0}}} : dividend_i;
    end else if (busy_q) begin
      quo_q <= {quo_q[XLEN-2:0], ge};
      rem_q <= ge ? diff : partial[XLEN-1:0];
      cnt_q <= cnt_q + CNT_W'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/mext_exec.sv
// M-extension execute sequencer: drives the external multiplier, runs the
// iterative divider and holds a single result for writeback.
module mext_exec
  import mext_exec_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  op_t             in_op,
  input  logic            in_is_word_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            mul_enable,
  output mul::op_t        mul_op,
  output logic            mul_is_word_op,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  input  logic [XLEN-1:0] mul_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);
  typedef enum logic [2:0] {IDLE, MUL_LAUNCH, MUL_CAPT, DIV_RUN, DIV_FIX, RESP} state_t;

  localparam logic [XLEN-1:0] DMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] WMIN = {{(XLEN/2+1){1'b1}}, {(XLEN/2-1){1'b0}}};

  state_t          state_q;
  op_t             op_q;
  logic            word_q, qneg_q, rneg_q, special_q, valid_q, mul_en_q;
  logic [XLEN-1:0] a_q, b_q, forced_q, res_q;

  logic            signed_op, is_rem_in, sa, sb, div_zero, ovf, special;
  logic [XLEN-1:0] ea, eb, ma, mb, forced, min_neg;
  logic            accept, kill, div_start, div_busy, div_done, is_rem;
  logic [XLEN-1:0] div_quo, div_rem, raw, fix_result;

  // Divide operand preparation on the incoming op: width extension,
  // magnitudes, result signs and the forced results for special cases.
  always_comb begin
    signed_op = (in_op == DIV) || (in_op == REM);
    is_rem_in = (in_op == REM) || (in_op == REMU);
    if (in_is_word_op) begin
      ea = signed_op ? {{(XLEN/2){in_a[XLEN/2-1]}}, in_a[XLEN/2-1:0]}
                     : {{(XLEN/2){1'b0}}, in_a[XLEN/2-1:0]};
      eb = signed_op ? {{(XLEN/2){in_b[XLEN/2-1]}}, in_b[XLEN/2-1:0]}
                     : {{(XLEN/2){1'b0}}, in_b[XLEN/2-1:0]};
    end else begin
      ea = in_a;
      eb = in_b;
    end
    sa       = signed_op & ea[XLEN-1];
    sb       = signed_op & eb[XLEN-1];
    ma       = sa ? -ea : ea;
    mb       = sb ? -eb : eb;
    min_neg  = in_is_word_op ? WMIN : DMIN;
    div_zero = (eb == '0);
    ovf      = signed_op && (ea == min_neg) && (eb == '1);
    special  = div_zero || ovf;
    if (div_zero) forced = is_rem_in ? ea : '1;
    else          forced = is_rem_in ? '0 : ea;
  end

  // Sign fix-up and result selection once the divider has finished.
  always_comb begin
    is_rem = (op_q == REM) || (op_q == REMU);
    if (special_q)   raw = forced_q;
    else if (is_rem) raw = rneg_q ? -div_rem : div_rem;
    else             raw = qneg_q ? -div_quo : div_quo;
    fix_result = word_q ? {{(XLEN/2){raw[XLEN/2-1]}}, raw[XLEN/2-1:0]} : raw;
  end

  assign accept    = (state_q == IDLE) && in_valid && !flush;
  assign kill      = flush && (state_q != IDLE);
  assign div_start = accept && is_div(in_op) && !special;

  mext_exec_div_iter u_div (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .start_i     (div_start),
    .clear_i     (kill),
    .word_i      (in_is_word_op),
    .dividend_i  (ma),
    .divisor_i   (mb),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Sequencer: accept, mul launch/capture, divide run/fix, response hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= MUL;
      word_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      special_q <= 1'b0;
      forced_q  <= '0;
      res_q     <= '0;
      valid_q   <= 1'b0;
      mul_en_q  <= 1'b0;
    end else if (kill) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      mul_en_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q      <= in_op;
          word_q    <= in_is_word_op;
          a_q       <= in_a;
          b_q       <= in_b;
          qneg_q    <= sa ^ sb;
          rneg_q    <= sa;
          special_q <= special;
          forced_q  <= forced;
          if (is_div(in_op)) begin
            state_q <= special ? DIV_FIX : DIV_RUN;
          end else begin
            mul_en_q <= 1'b1;
            state_q  <= MUL_LAUNCH;
          end
        end
        MUL_LAUNCH: begin
          mul_en_q <= 1'b0;
          state_q  <= MUL_CAPT;
        end
        MUL_CAPT: begin
          res_q   <= mul_result;
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        DIV_RUN: if (div_done || !div_busy) state_q <= DIV_FIX;
        DIV_FIX: begin
          res_q   <= fix_result;
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: if (out_ready) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign mul_enable     = mul_en_q;
  assign mul_op         = to_mul_op(op_q);
  assign mul_is_word_op = word_q;
  assign mul_a          = a_q;
  assign mul_b          = b_q;
  assign out_valid      = valid_q;
  assign out_result     = res_q;
endmodule
